// File: rtl/edge_event_arbiter_pkg.sv
// Shared definitions for the edge event arbiter.
// Contents:
//   N_CH_DEF, SYNC_STAGES_DEF - parameter defaults
//   MAX_CH                    - largest supported channel count
//   calc_idw()                - channel index width for a channel count
//   state_e                   - arbiter FSM states
//   rr_pick()                 - round-robin find-first-set
package edge_evt_pkg;

  localparam int N_CH_DEF        = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int MAX_CH          = 16;

  function automatic int calc_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  // Returns the first set bit of vec[n-1:0], starting at 'start' and
  // wrapping from n-1 to 0. Scanning from the far end lets the smallest
  // offset overwrite the result last. Returns 0 when nothing is set.
  function automatic int rr_pick(input logic [MAX_CH-1:0] vec,
                                 input int n, input int start);
    int idx;
    int pick;
    pick = 0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      idx = start + i;
      if (idx >= n) idx = idx - n;
      if (i < n && vec[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Valid/ready event channel between the arbiter and its consumer.
// Signals:
//   evt_valid - event offered (arbiter -> consumer)
//   evt_id    - channel index of offered event (arbiter -> consumer)
//   evt_ready - consumer accepts this cycle (consumer -> arbiter)
interface edge_event_arbiter_if #(
  parameter int IDW = edge_evt_pkg::calc_idw(edge_evt_pkg::N_CH_DEF)
);
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic           evt_ready;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/edge_event_arbiter_chan.sv
// One input channel: synchroniser, rising-edge detect, pending and
// sticky overflow flags.
// Ports:
//   clk, rst     - clock, async active-high reset
//   din          - asynchronous level input
//   clear        - this channel's event is handed over this cycle
//   ovf_clr      - synchronous clear of the overflow flag
//   pending      - registered pending flag
//   pending_nxt  - value pending takes at the next edge
//   ovf          - sticky overflow flag
module edge_evt_chan
  import edge_evt_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic clear,
  input  logic ovf_clr,
  output logic pending,
  output logic pending_nxt,
  output logic ovf
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES:0]   arm_q, arm_d;
  logic prev_q, prev_d;
  logic pending_q, pending_d;
  logic ovf_q, ovf_d;
  logic s, rise;

  // The synchroniser restarts from zero after reset, so an input already
  // high would look like a fresh edge. arm_q masks edges until the chain
  // and edge history have caught up with the real input level.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], din};
    arm_d     = {arm_q[SYNC_STAGES-1:0], 1'b1};
    s         = sync_q[SYNC_STAGES-1];
    prev_d    = s;
    rise      = s & ~prev_q & arm_q[SYNC_STAGES];
    // A new edge on the grant cycle keeps the event alive.
    pending_d = rise | (pending_q & ~clear);
    // Edge merged into an event that is still waiting; set beats clear.
    ovf_d     = (rise & pending_q & ~clear) | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      arm_q     <= '0;
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      arm_q     <= arm_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pending     = pending_q;
  assign pending_nxt = pending_d;
  assign ovf         = ovf_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel rising-edge event scheduler. Edges on din are latched
// per channel and handed, one per transfer, round-robin to a consumer.
// Ports:
//   clk, rst  - clock, async active-high reset
//   din       - asynchronous level inputs
//   evt       - valid/ready event channel (master side)
//   pending   - latched events not yet granted (incl. the offered one)
//   ovf       - sticky per-channel overflow flags
//   ovf_clr   - per-bit synchronous clear of ovf
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int IDW         = calc_idw(N_CH),
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     din,
  edge_event_arbiter_if.master evt,
  output logic [N_CH-1:0]     pending,
  output logic [N_CH-1:0]     ovf,
  input  logic [N_CH-1:0]     ovf_clr
);

  state_e            state_q, state_d;
  logic [IDW-1:0]    rr_q, rr_d;
  logic [IDW-1:0]    evt_id_q, evt_id_d;
  logic [IDW-1:0]    ptr_after;
  logic [N_CH-1:0]   clear;
  logic [N_CH-1:0]   pend_nxt;
  logic [MAX_CH-1:0] pend_vec;
  logic [MAX_CH-1:0] other_vec;
  logic              handshake;

  for (genvar c = 0; c < N_CH; c++) begin : g_chan
    edge_evt_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan (
      .clk         (clk),
      .rst         (rst),
      .din         (din[c]),
      .clear       (clear[c]),
      .ovf_clr     (ovf_clr[c]),
      .pending     (pending[c]),
      .pending_nxt (pend_nxt[c]),
      .ovf         (ovf[c])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      evt_id_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      evt_id_q <= evt_id_d;
    end
  end

  // On a handshake the next winner comes from next-cycle pending with the
  // granted channel masked, so a same-cycle re-edge on it waits one
  // arbitration and then sits last behind the advanced pointer.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    evt_id_d  = evt_id_q;
    pend_vec  = '0;
    pend_vec[N_CH-1:0]  = pending;
    other_vec = '0;
    other_vec[N_CH-1:0] = pend_nxt & ~clear;
    ptr_after = (int'(evt_id_q) == N_CH - 1) ? '0 : evt_id_q + IDW'(1);
    case (state_q)
      IDLE: begin
        if (|pending) begin
          evt_id_d = IDW'(rr_pick(pend_vec, N_CH, int'(rr_q)));
          state_d  = OFFER;
        end
      end
      OFFER: begin
        if (handshake) begin
          rr_d = ptr_after;
          if (|other_vec) begin
            evt_id_d = IDW'(rr_pick(other_vec, N_CH, int'(ptr_after)));
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    evt.evt_valid = (state_q == OFFER);
    evt.evt_id    = evt_id_q;
    handshake     = (state_q == OFFER) & evt.evt_ready;
    clear         = '0;
    if (handshake) clear[evt_id_q] = 1'b1;
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed, table-driven bench for edge_event_arbiter (N_CH=4, 2-stage sync).
module tb_edge_event_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] din = '1;
  logic [N-1:0] ovf_clr = '0;
  logic [N-1:0] pending;
  logic [N-1:0] ovf;
  int           tests = 0;
  int           fails = 0;

  edge_event_arbiter_if #(.IDW(W)) evt_if ();

  edge_event_arbiter #(.N_CH(N), .IDW(W), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .evt     (evt_if),
    .pending (pending),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] din;
    logic         ready;
    logic [N-1:0] clr;
    logic         exp_valid;
    logic [W-1:0] exp_id;
    logic [N-1:0] exp_pend;
    logic [N-1:0] exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic [N-1:0] d, input logic r, input logic [N-1:0] c,
                        input logic v, input logic [W-1:0] id,
                        input logic [N-1:0] p, input logic [N-1:0] o);
    vec_t t;
    t.din = d; t.ready = r; t.clr = c;
    t.exp_valid = v; t.exp_id = id; t.exp_pend = p; t.exp_ovf = o;
    vecs.push_back(t);
  endtask

  // Drive inputs away from the edge, then sample 1 time unit after it.
  task automatic applyStimulus(input logic [N-1:0] d, input logic r, input logic [N-1:0] c);
    din = d;
    evt_if.evt_ready = r;
    ovf_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic v, input logic [W-1:0] id,
                             input logic [N-1:0] p, input logic [N-1:0] o);
    tests++;
    if (evt_if.evt_valid !== v) begin
      fails++;
      $display("[TB] FAIL %s evt_valid: got %b expected %b", tag, evt_if.evt_valid, v);
    end
    if (v) begin
      tests++;
      if (evt_if.evt_id !== id) begin
        fails++;
        $display("[TB] FAIL %s evt_id: got %0d expected %0d", tag, evt_if.evt_id, id);
      end
    end
    tests++;
    if (pending !== p) begin
      fails++;
      $display("[TB] FAIL %s pending: got %b expected %b", tag, pending, p);
    end
    tests++;
    if (ovf !== o) begin
      fails++;
      $display("[TB] FAIL %s ovf: got %b expected %b", tag, ovf, o);
    end
  endtask

  initial begin
    evt_if.evt_ready = 1'b0;

    // Round robin: all four rise together, then 0 and 1 re-rise.
    addVec(4'b1111, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    addVec(4'b1111, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    addVec(4'b1111, 1, 4'b0000, 0, 0, 4'b1111, 4'b0000);
    addVec(4'b1111, 1, 4'b0000, 1, 0, 4'b1111, 4'b0000);
    addVec(4'b1111, 1, 4'b0000, 1, 1, 4'b1110, 4'b0000);
    addVec(4'b1111, 1, 4'b0000, 1, 2, 4'b1100, 4'b0000);
    addVec(4'b1111, 1, 4'b0000, 1, 3, 4'b1000, 4'b0000);
    addVec(4'b1111, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    addVec(4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    addVec(4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    addVec(4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    addVec(4'b0011, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    addVec(4'b0011, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    addVec(4'b0011, 1, 4'b0000, 0, 0, 4'b0011, 4'b0000);
    addVec(4'b0011, 1, 4'b0000, 1, 0, 4'b0011, 4'b0000);
    addVec(4'b0011, 1, 4'b0000, 1, 1, 4'b0010, 4'b0000);
    addVec(4'b0011, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    // Single edge on ch2 while ch0/ch1 stay high (no repeat events).
    addVec(4'b0111, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    addVec(4'b0111, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    addVec(4'b0111, 1, 4'b0000, 0, 0, 4'b0100, 4'b0000);
    addVec(4'b0111, 1, 4'b0000, 1, 2, 4'b0100, 4'b0000);
    addVec(4'b0111, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    // Backpressure and overflow on ch1.
    addVec(4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    addVec(4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    addVec(4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    addVec(4'b0010, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    addVec(4'b0010, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    addVec(4'b0010, 0, 4'b0000, 0, 0, 4'b0010, 4'b0000);
    addVec(4'b0010, 0, 4'b0000, 1, 1, 4'b0010, 4'b0000);
    addVec(4'b0000, 0, 4'b0000, 1, 1, 4'b0010, 4'b0000);
    addVec(4'b0000, 0, 4'b0000, 1, 1, 4'b0010, 4'b0000);
    addVec(4'b0000, 0, 4'b0000, 1, 1, 4'b0010, 4'b0000);
    addVec(4'b0010, 0, 4'b0000, 1, 1, 4'b0010, 4'b0000);
    addVec(4'b0010, 0, 4'b0000, 1, 1, 4'b0010, 4'b0000);
    addVec(4'b0010, 0, 4'b0000, 1, 1, 4'b0010, 4'b0010);
    addVec(4'b0010, 1, 4'b0000, 0, 0, 4'b0000, 4'b0010);
    addVec(4'b0010, 1, 4'b0000, 0, 0, 4'b0000, 4'b0010);
    addVec(4'b0010, 0, 4'b0010, 0, 0, 4'b0000, 4'b0000);
    addVec(4'b0010, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);

    // Reset held with inputs high, then released with inputs still high.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1111, 0, 4'b0000);
      checkOutput($sformatf("reset_hold%0d", i), 0, 0, 4'b0000, 4'b0000);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1111, 0, 4'b0000);
      checkOutput($sformatf("release_high%0d", i), 0, 0, 4'b0000, 4'b0000);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0000, 0, 4'b0000);
      checkOutput($sformatf("fall%0d", i), 0, 0, 4'b0000, 4'b0000);
    end

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].din, vecs[i].ready, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_id,
                  vecs[i].exp_pend, vecs[i].exp_ovf);
    end

    // Ch0 offered; its next edge lands on the very cycle it is granted.
    applyStimulus(4'b0011, 0, 4'b0000); checkOutput("same0", 0, 0, 4'b0000, 4'b0000);
    applyStimulus(4'b0011, 0, 4'b0000); checkOutput("same1", 0, 0, 4'b0000, 4'b0000);
    applyStimulus(4'b0011, 0, 4'b0000); checkOutput("same2", 0, 0, 4'b0001, 4'b0000);
    applyStimulus(4'b0011, 0, 4'b0000); checkOutput("same3", 1, 0, 4'b0001, 4'b0000);
    applyStimulus(4'b0010, 0, 4'b0000); checkOutput("same4", 1, 0, 4'b0001, 4'b0000);
    applyStimulus(4'b0010, 0, 4'b0000); checkOutput("same5", 1, 0, 4'b0001, 4'b0000);
    applyStimulus(4'b0010, 0, 4'b0000); checkOutput("same6", 1, 0, 4'b0001, 4'b0000);
    applyStimulus(4'b0011, 0, 4'b0000); checkOutput("same7", 1, 0, 4'b0001, 4'b0000);
    applyStimulus(4'b0011, 0, 4'b0000); checkOutput("same8", 1, 0, 4'b0001, 4'b0000);
    applyStimulus(4'b0011, 1, 4'b0000); checkOutput("same_grant", 0, 0, 4'b0001, 4'b0000);
    applyStimulus(4'b0011, 0, 4'b0000); checkOutput("same_reoffer", 1, 0, 4'b0001, 4'b0000);
    applyStimulus(4'b0011, 1, 4'b0000); checkOutput("same_done", 0, 0, 4'b0000, 4'b0000);

    // Asynchronous reset while ch3 is being offered.
    applyStimulus(4'b1011, 0, 4'b0000); checkOutput("rmid0", 0, 0, 4'b0000, 4'b0000);
    applyStimulus(4'b1011, 0, 4'b0000); checkOutput("rmid1", 0, 0, 4'b0000, 4'b0000);
    applyStimulus(4'b1011, 0, 4'b0000); checkOutput("rmid2", 0, 0, 4'b1000, 4'b0000);
    applyStimulus(4'b1011, 0, 4'b0000); checkOutput("rmid3", 1, 3, 4'b1000, 4'b0000);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rmid_async", 0, 0, 4'b0000, 4'b0000);
    applyStimulus(4'b1011, 0, 4'b0000); checkOutput("rmid_hold", 0, 0, 4'b0000, 4'b0000);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1011, 1, 4'b0000);
      checkOutput($sformatf("rmid_after%0d", i), 0, 0, 4'b0000, 4'b0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
Multi-channel rising-edge event scheduler. It synchronises N asynchronous level inputs and detects a rising edge on each. Each edge is latched as a pending event. Pending events are granted one at a time, round-robin, to a single shared downstream consumer over a valid/ready handshake. The block sits between raw external strobes/buttons and the shared event-handling logic that consumes one event per transfer.

Parameters:
N_CH, 4, number of input channels (2..16)
IDW, $clog2(N_CH), width of channel index
SYNC_STAGES, 2, synchroniser flops per channel (>=2)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  reset; one clock; asynchronous, active-high
din  input  N_CH  asynchronous level inputs, one per channel
evt_valid  output  1  event offered to consumer
evt_id  output  IDW  channel index of offered event
evt_ready  input  1  consumer accepts offered event this cycle
pending  output  N_CH  latched-but-not-yet-granted events (includes offered one)
ovf  output  N_CH  sticky per-channel overflow flags
ovf_clr  input  N_CH  per-bit synchronous clear of ovf

Behaviour:
- Reset (async assert, sync release by system): all sync flops, edge history, pending, ovf, evt_valid = 0; evt_id = 0; rr pointer = 0; FSM = IDLE. Reset mid-transfer drops the offered event and all pending events without a handshake.
- Per channel: SYNC_STAGES flop chain to produce s. prev <= s. rise = s & ~prev. Levels held high give exactly one rise.
- pending[c] next value:
  - set on rise[c];
  - cleared on handshake (evt_valid & evt_ready & evt_id==c);
  - if rise and clear occur in the same cycle, pending stays 1 (new event kept, no overflow).
- ovf[c] sets when rise[c] occurs while pending[c]=1 and no clear of c happens that cycle. The event is merged and not queued. ovf_clr[c] clears the flag; if set and clear coincide, set wins.
- FSM:
  - IDLE: evt_valid=0. If any pending bit is set, select the first set bit starting at rr pointer, wrapping N_CH-1 -> 0. Register it into evt_id, set evt_valid=1, go to OFFER.
  - OFFER: evt_valid=1 and evt_id held stable until evt_ready (no withdrawal, no id change).
  - On handshake: rr pointer <= evt_id+1 (mod N_CH).
    - If any other pending bit (excluding evt_id, using the next-cycle pending value) is set, load the next winner searched from the new pointer and stay in OFFER (back-to-back, one event per cycle).
    - Otherwise go to IDLE.
  - A channel re-pending on the same cycle as its grant is eligible in the next arbitration. It is searched last because of the pointer advance.
- Latency (SYNC_STAGES=2): din first sampled high at edge k -> s high after k+1 -> pending set at k+2 -> evt_valid/evt_id valid after edge k+3.
- Fairness: any pending channel is granted within N_CH handshakes.
- Widths: evt_id is IDW bits. N_CH that is not a power of two wraps explicitly; indices >= N_CH are never produced.

Decomposition:
- Package edge_evt_pkg:
  - parameter defaults N_CH, SYNC_STAGES;
  - IDW derivation function;
  - FSM state enum {IDLE, OFFER};
  - round-robin find-first-set function (vector, start) -> index.
- Sub-module edge_evt_chan, one per channel: synchroniser, prev flop, rise, pending and ovf flops. The inputs are clear and ovf_clr; the outputs are pending and ovf. The top level holds the FSM, rr pointer and output registers.

Test Plan:
- Reset: hold rst=1 with din=4'b1111 -> evt_valid=0, pending=0, ovf=0. Release with din still high -> no events.
- Single edge: din[2] 0->1 at edge k, evt_ready=1 -> evt_valid=1, evt_id=2 after edge k+3 for one cycle; pending returns to 0.
- Round robin: din=4'b1111 rising together, evt_ready=1 -> ids 0,1,2,3 on four consecutive cycles. Then din 0 and 1 re-rise -> next order is 0,1 (pointer at 0 after wrap).
- Backpressure/overflow: evt_ready=0, two rising edges on ch1 -> evt_id=1 held stable, pending[1]=1, ovf[1]=1. Assert evt_ready -> one handshake only. ovf_clr[1] -> ovf[1]=0.
- Simultaneous rise and grant: ch0 offered, evt_ready=1 in the same cycle rise[0]=1 -> pending[0] stays 1, ovf[0]=0, and ch0 is granted again later.
- Reset mid-offer: evt_valid=1, evt_ready=0, assert rst asynchronously between edges -> evt_valid drops immediately, pending=0.
